// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel/line counters with horizontal and vertical
// phase FSMs, producing registered sync, blanking and start-of-line/frame strobes.
`timescale 1ns/1ps
module vga_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
)(
   input  logic       clk,
   input  logic       clr,
   input  logic       pix_en,
   input  logic       run,
   input  logic       restart,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       line_start,
   output logic       frame_start
);

   // Both totals must fit the 10-bit counters (at most 1024).
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
   localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
   localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
   localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
   localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

   typedef enum logic [1:0] {HST_ACT, HST_FP, HST_SYNC, HST_BP} h_state_t;
   typedef enum logic [1:0] {VST_ACT, VST_FP, VST_SYNC, VST_BP} v_state_t;

   h_state_t   h_state, h_state_nxt;
   v_state_t   v_state, v_state_nxt;
   logic [9:0] hcount_nxt, vcount_nxt;
   logic       line_evt, line_evt_nxt;
   logic       frame_evt, frame_evt_nxt;
   logic       advance, h_wrap, v_wrap;

   assign advance = pix_en & run;
   assign h_wrap  = (hcount == H_LAST);
   assign v_wrap  = (vcount == V_LAST);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      hcount_nxt    = hcount;
      vcount_nxt    = vcount;
      h_state_nxt   = h_state;
      v_state_nxt   = v_state;
      line_evt_nxt  = 1'b0;
      frame_evt_nxt = 1'b0;
      if (restart) begin
         hcount_nxt    = '0;
         vcount_nxt    = '0;
         h_state_nxt   = HST_ACT;
         v_state_nxt   = VST_ACT;
         line_evt_nxt  = 1'b1;
         frame_evt_nxt = 1'b1;
      end else if (advance) begin
         hcount_nxt = h_wrap ? '0 : hcount + 10'd1;
         case (h_state)
            HST_ACT:  if (hcount == H_ACT_END)  h_state_nxt = HST_FP;
            HST_FP:   if (hcount == H_FP_END)   h_state_nxt = HST_SYNC;
            HST_SYNC: if (hcount == H_SYNC_END) h_state_nxt = HST_BP;
            HST_BP:   if (h_wrap)               h_state_nxt = HST_ACT;
            default:                            h_state_nxt = HST_ACT;
         endcase
         // The vertical machine only moves on the advance that ends a line.
         if (h_wrap) begin
            line_evt_nxt  = 1'b1;
            frame_evt_nxt = v_wrap;
            vcount_nxt    = v_wrap ? '0 : vcount + 10'd1;
            case (v_state)
               VST_ACT:  if (vcount == V_ACT_END)  v_state_nxt = VST_FP;
               VST_FP:   if (vcount == V_FP_END)   v_state_nxt = VST_SYNC;
               VST_SYNC: if (vcount == V_SYNC_END) v_state_nxt = VST_BP;
               VST_BP:   if (v_wrap)               v_state_nxt = VST_ACT;
               default:                            v_state_nxt = VST_ACT;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hcount    <= '0;
         vcount    <= '0;
         h_state   <= HST_ACT;
         v_state   <= VST_ACT;
         line_evt  <= 1'b0;
         frame_evt <= 1'b0;
      end else begin
         hcount    <= hcount_nxt;
         vcount    <= vcount_nxt;
         h_state   <= h_state_nxt;
         v_state   <= v_state_nxt;
         line_evt  <= line_evt_nxt;
         frame_evt <= frame_evt_nxt;
      end
   end

   // Decoded outputs lag the counters/states by one clock.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= (h_state != HST_SYNC);
         vsync       <= (v_state != VST_SYNC);
         video_on    <= (h_state == HST_ACT) && (v_state == VST_ACT) && run;
         line_start  <= line_evt;
         frame_start <= frame_evt;
      end
   end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, default 96: horizontal sync-pulse pixels.
REQ-004 Parameter H_BP, default 48: horizontal back-porch pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front-porch lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync-pulse lines.
REQ-008 Parameter V_BP, default 33: vertical back-porch lines.
REQ-009 clk  input  1  system clock, 100 MHz.
REQ-010 clr  input  1  reset, asynchronous, active-high.
REQ-011 pix_en  input  1  pixel-rate enable; one-clk pulse every 4 clks from the clock divider.
REQ-012 run  input  1  level; 1 = timing advances, 0 = timing frozen.
REQ-013 restart  input  1  one-clk synchronous request to return to line 0, pixel 0.
REQ-014 hsync  output  1  horizontal sync, active-low.
REQ-015 vsync  output  1  vertical sync, active-low.
REQ-016 video_on  output  1  high during visible region.
REQ-017 hcount  output  10  current pixel index.
REQ-018 vcount  output  10  current line index.
REQ-019 line_start  output  1  one-clk pulse at each line start.
REQ-020 frame_start  output  1  one-clk pulse at each frame start.

Function
REQ-021 The block SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525), both ≤ 1024.
REQ-022 Counters SHALL advance only on clk edges where pix_en=1 and run=1; at all other edges they hold.
REQ-023 On an advance, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment, with vcount wrapping from V_TOTAL-1 to 0.
REQ-024 The horizontal FSM SHALL use states H_ACT (0..H_ACTIVE-1), H_FP, H_SYNC and H_BP, moving to the next state on the advance that crosses each boundary; H_BP SHALL return to H_ACT on wrap.
REQ-025 The vertical FSM SHALL use states V_ACT, V_FP, V_SYNC and V_BP with the same boundary rule; it SHALL transition only on an advance that wraps hcount.
REQ-026 Horizontal boundaries SHALL be: H_FP from 640, H_SYNC 656..751, H_BP 752..799; vertical boundaries SHALL be: V_FP from 480, V_SYNC 490..491, V_BP 492..524 (defaults).
REQ-027 hsync, vsync, video_on, line_start and frame_start SHALL be registered, reflecting the counter/state values one clk after they update (latency 1 clk).
REQ-028 hsync SHALL be 0 exactly in H_SYNC; vsync SHALL be 0 exactly in V_SYNC.
REQ-029 video_on SHALL be 1 only when the horizontal FSM is in H_ACT, the vertical FSM is in V_ACT and run=1.
REQ-030 line_start SHALL pulse for one clk after hcount becomes 0 through an advance or restart; frame_start SHALL pulse for one clk after both counters become 0.
REQ-031 When run=0, counters and FSMs SHALL hold, video_on SHALL be 0 from the next clk, and hsync/vsync SHALL hold their decoded values.
REQ-032 On restart=1, counters SHALL go to (0,0) and both FSMs to ACT on that edge regardless of pix_en/run; restart SHALL take priority over a simultaneous advance, and line_start/frame_start SHALL pulse on the following clk.
REQ-033 pix_en asserted on consecutive clks SHALL cause one advance per clk, with no internal rate check.

Reset
REQ-034 While clr=1: hcount=0, vcount=0, both FSMs in ACT, hsync=1, vsync=1, video_on=0, line_start=0, frame_start=0.
REQ-035 clr asserted mid-line or mid-frame SHALL take effect immediately, independent of clk; the first advance after release SHALL move to (1,0).

Verification
REQ-036 Reset, then run=1 with pix_en every 4th clk for 800 advances -> hsync=0 exactly for hcount 656..751 and line_start pulses once after the wrap to 0.
REQ-037 Full frame (420000 advances) -> vsync low for exactly 1600 advances (lines 490..491); frame_start pulses once; video_on high for 307200 advances.
REQ-038 run=0 at hcount=300 for 50 clks -> hcount stays 300, video_on=0 one clk later, and counting resumes at 301 after run returns to 1.
REQ-039 restart and pix_en asserted together at (700,200) -> next state (0,0), not (701,200); line_start=1 and frame_start=1 on the following clk.
REQ-040 clr pulsed between clk edges at (799,524) -> outputs go to reset values immediately, with no frame_start pulse.
